// File: rtl/depacketizer.sv
`default_nettype none
// ============================================================================
//  Module      : depacketizer
//  Description : Replays one scheduled packet at a time as an AXI4 master
//                read (AR) or write (AW + W burst + B) transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module depacketizer #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 7,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_M_AXI_USER_WIDTH = 1,
    parameter int MAX_BURST_LEN      = 4,
    parameter int MAX_OUTSTANDING_RD = 4
) (
    input  logic                                    M_AXI_ACLK,
    input  logic                                    M_AXI_ARESETN,
    input  logic [102+16*MAX_BURST_LEN+MAX_BURST_LEN*C_M_AXI_DATA_WIDTH-1:0] packetIn,
    input  logic                                    packetValid,
    output logic                                    ready,
    output logic [C_M_AXI_ID_WIDTH-1:0]             M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]           M_AXI_AWADDR,
    output logic [7:0]                              M_AXI_AWLEN,
    output logic [2:0]                              M_AXI_AWSIZE,
    output logic [1:0]                              M_AXI_AWBURST,
    output logic                                    M_AXI_AWLOCK,
    output logic [3:0]                              M_AXI_AWCACHE,
    output logic [2:0]                              M_AXI_AWPROT,
    output logic [3:0]                              M_AXI_AWQOS,
    output logic [3:0]                              M_AXI_AWREGION,
    output logic [C_M_AXI_USER_WIDTH-1:0]           M_AXI_AWUSER,
    output logic                                    M_AXI_AWVALID,
    input  logic                                    M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]           M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
    output logic                                    M_AXI_WLAST,
    output logic                                    M_AXI_WVALID,
    input  logic                                    M_AXI_WREADY,
    input  logic [1:0]                              M_AXI_BRESP,
    input  logic                                    M_AXI_BVALID,
    output logic                                    M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]             M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
    output logic [7:0]                              M_AXI_ARLEN,
    output logic [2:0]                              M_AXI_ARSIZE,
    output logic [1:0]                              M_AXI_ARBURST,
    output logic                                    M_AXI_ARLOCK,
    output logic [3:0]                              M_AXI_ARCACHE,
    output logic [2:0]                              M_AXI_ARPROT,
    output logic [3:0]                              M_AXI_ARQOS,
    output logic [3:0]                              M_AXI_ARREGION,
    output logic [C_M_AXI_USER_WIDTH-1:0]           M_AXI_ARUSER,
    output logic                                    M_AXI_ARVALID,
    input  logic                                    M_AXI_ARREADY,
    input  logic                                    M_AXI_RVALID,
    input  logic                                    M_AXI_RREADY,
    input  logic                                    M_AXI_RLAST,
    output logic                                    bresp_err
);

    localparam int c_STRB_W   = C_M_AXI_DATA_WIDTH / 8;
    localparam int c_STRB_LO  = MAX_BURST_LEN * C_M_AXI_DATA_WIDTH;
    localparam int c_META_LO  = c_STRB_LO + 16 * MAX_BURST_LEN;
    localparam int c_IDX_W    = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1;
    localparam int c_RDO_W    = $clog2(MAX_OUTSTANDING_RD + 1);

    localparam int c_O_USER   = 0;
    localparam int c_O_REGION = c_O_USER + C_M_AXI_USER_WIDTH;
    localparam int c_O_QOS    = c_O_REGION + 4;
    localparam int c_O_PROT   = c_O_QOS + 4;
    localparam int c_O_CACHE  = c_O_PROT + 3;
    localparam int c_O_LOCK   = c_O_CACHE + 4;
    localparam int c_O_BURST  = c_O_LOCK + 1;
    localparam int c_O_SIZE   = c_O_BURST + 2;
    localparam int c_O_LEN    = c_O_SIZE + 3;
    localparam int c_O_ID     = c_O_LEN + 8;
    localparam int c_O_ADDR   = c_O_ID + C_M_AXI_ID_WIDTH;
    localparam int c_O_RW     = c_O_ADDR + C_M_AXI_ADDR_WIDTH;

    localparam logic [c_RDO_W-1:0] c_MAX_RD = c_RDO_W'(MAX_OUTSTANDING_RD);
    localparam logic [7:0]         c_MAX_BL = 8'(MAX_BURST_LEN);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_RD_ADDR = 2'd1;
    localparam logic [1:0] c_S_WR      = 2'd2;
    localparam logic [1:0] c_S_WR_RESP = 2'd3;

    logic [1:0]                    r_state;
    logic [1:0]                    w_state_nxt;
    logic [101:0]                  w_meta;
    logic [C_M_AXI_DATA_WIDTH-1:0] w_slot_data [MAX_BURST_LEN];
    logic [c_STRB_W-1:0]           w_slot_strb [MAX_BURST_LEN];
    logic [C_M_AXI_DATA_WIDTH-1:0] r_data [MAX_BURST_LEN];
    logic [c_STRB_W-1:0]           r_strb [MAX_BURST_LEN];

    logic [C_M_AXI_ID_WIDTH-1:0]   r_id;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                    r_len;
    logic [2:0]                    r_size;
    logic [1:0]                    r_burst;
    logic                          r_lock;
    logic [3:0]                    r_cache;
    logic [2:0]                    r_prot;
    logic [3:0]                    r_qos;
    logic [3:0]                    r_region;
    logic [C_M_AXI_USER_WIDTH-1:0] r_user;

    logic [7:0]                    r_beat;
    logic                          r_aw_done;
    logic                          r_w_done;
    logic [c_RDO_W-1:0]            r_rd_out;
    logic [c_RDO_W-1:0]            w_rd_out_nxt;
    logic                          r_ready;
    logic                          r_bresp_err;

    logic w_accept;
    logic w_arvalid, w_awvalid, w_wvalid, w_wlast, w_bready;
    logic w_ar_hs, w_aw_hs, w_w_hs, w_b_hs, w_r_last;
    logic w_beat_in_range;
    logic [c_IDX_W-1:0] w_idx;
    logic w_unused;

    assign w_meta   = packetIn[c_META_LO +: 102];
    assign w_unused = ^{packetIn, r_beat};

    // Beat 0 sits in the most-significant slot of both the data and strobe arrays
    generate
        for (genvar gi = 0; gi < MAX_BURST_LEN; gi++) begin : g_slot
            assign w_slot_data[gi] = packetIn[(MAX_BURST_LEN-gi)*C_M_AXI_DATA_WIDTH-1 -: C_M_AXI_DATA_WIDTH];
            assign w_slot_strb[gi] = packetIn[c_STRB_LO + (MAX_BURST_LEN-1-gi)*16 +: c_STRB_W];
        end
    endgenerate

    assign w_accept = packetValid & r_ready;
    assign w_ar_hs  = w_arvalid & M_AXI_ARREADY;
    assign w_aw_hs  = w_awvalid & M_AXI_AWREADY;
    assign w_w_hs   = w_wvalid  & M_AXI_WREADY;
    assign w_b_hs   = w_bready  & M_AXI_BVALID;
    assign w_r_last = M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST & (r_rd_out != '0);

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:    if (w_accept) w_state_nxt = w_meta[c_O_RW] ? c_S_WR : c_S_RD_ADDR;
            c_S_RD_ADDR: if (M_AXI_ARREADY) w_state_nxt = c_S_IDLE;
            c_S_WR:      if ((r_aw_done | w_aw_hs) & (r_w_done | (w_w_hs & w_wlast)))
                             w_state_nxt = c_S_WR_RESP;
            c_S_WR_RESP: if (M_AXI_BVALID) w_state_nxt = c_S_IDLE;
            default:     w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_arvalid = 1'b0;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        case (r_state)
            c_S_RD_ADDR: w_arvalid = 1'b1;
            c_S_WR: begin
                w_awvalid = ~r_aw_done;
                w_wvalid  = ~r_w_done;
            end
            c_S_WR_RESP: w_bready = 1'b1;
            default: ;
        endcase
        w_wlast = w_wvalid & (r_beat == r_len);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_lock   <= 1'b0;
            r_cache  <= '0;
            r_prot   <= '0;
            r_qos    <= '0;
            r_region <= '0;
            r_user   <= '0;
            for (int i = 0; i < MAX_BURST_LEN; i++) begin
                r_data[i] <= '0;
                r_strb[i] <= '0;
            end
        end else if (w_accept) begin
            r_id     <= w_meta[c_O_ID +: C_M_AXI_ID_WIDTH];
            r_addr   <= w_meta[c_O_ADDR +: C_M_AXI_ADDR_WIDTH];
            r_len    <= w_meta[c_O_LEN +: 8];
            r_size   <= w_meta[c_O_SIZE +: 3];
            r_burst  <= w_meta[c_O_BURST +: 2];
            r_lock   <= w_meta[c_O_LOCK];
            r_cache  <= w_meta[c_O_CACHE +: 4];
            r_prot   <= w_meta[c_O_PROT +: 3];
            r_qos    <= w_meta[c_O_QOS +: 4];
            r_region <= w_meta[c_O_REGION +: 4];
            r_user   <= w_meta[c_O_USER +: C_M_AXI_USER_WIDTH];
            for (int i = 0; i < MAX_BURST_LEN; i++) begin
                r_data[i] <= w_slot_data[i];
                r_strb[i] <= w_slot_strb[i];
            end
        end
    end

    // AW and W retire independently; each remembers its own completion
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_beat    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_accept) begin
            r_beat    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs) begin
                r_beat <= r_beat + 8'd1;
                if (w_wlast) r_w_done <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_out_nxt = r_rd_out;
        if (w_ar_hs && !w_r_last) begin
            w_rd_out_nxt = r_rd_out + c_RDO_W'(1);
        end else if (!w_ar_hs && w_r_last) begin
            w_rd_out_nxt = r_rd_out - c_RDO_W'(1);
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_rd_out    <= '0;
            r_ready     <= 1'b0;
            r_bresp_err <= 1'b0;
        end else begin
            r_rd_out <= w_rd_out_nxt;
            r_ready  <= (w_state_nxt == c_S_IDLE) && (w_rd_out_nxt < c_MAX_RD);
            if (w_b_hs && (M_AXI_BRESP != 2'b00)) r_bresp_err <= 1'b1;
        end
    end

    // Beats past the stored slots still go out, but carry no data or strobes
    assign w_beat_in_range = (r_beat < c_MAX_BL);
    assign w_idx           = r_beat[c_IDX_W-1:0];

    assign M_AXI_WDATA  = w_beat_in_range ? r_data[w_idx] : '0;
    assign M_AXI_WSTRB  = w_beat_in_range ? r_strb[w_idx] : '0;
    assign M_AXI_WLAST  = w_wlast;
    assign M_AXI_WVALID = w_wvalid;
    assign M_AXI_BREADY = w_bready;

    assign M_AXI_AWID     = r_id;
    assign M_AXI_AWADDR   = r_addr;
    assign M_AXI_AWLEN    = r_len;
    assign M_AXI_AWSIZE   = r_size;
    assign M_AXI_AWBURST  = r_burst;
    assign M_AXI_AWLOCK   = r_lock;
    assign M_AXI_AWCACHE  = r_cache;
    assign M_AXI_AWPROT   = r_prot;
    assign M_AXI_AWQOS    = r_qos;
    assign M_AXI_AWREGION = r_region;
    assign M_AXI_AWUSER   = r_user;
    assign M_AXI_AWVALID  = w_awvalid;

    assign M_AXI_ARID     = r_id;
    assign M_AXI_ARADDR   = r_addr;
    assign M_AXI_ARLEN    = r_len;
    assign M_AXI_ARSIZE   = r_size;
    assign M_AXI_ARBURST  = r_burst;
    assign M_AXI_ARLOCK   = r_lock;
    assign M_AXI_ARCACHE  = r_cache;
    assign M_AXI_ARPROT   = r_prot;
    assign M_AXI_ARQOS    = r_qos;
    assign M_AXI_ARREGION = r_region;
    assign M_AXI_ARUSER   = r_user;
    assign M_AXI_ARVALID  = w_arvalid;

    assign ready     = r_ready;
    assign bresp_err = r_bresp_err;

endmodule
`default_nettype wire

// File: tb/tb_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_depacketizer
//  Description : Directed self-checking bench for the depacketizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_depacketizer;

    localparam int c_DW = 128;
    localparam int c_PW = 102 + 64 + 4 * c_DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [c_PW-1:0] packetIn = '0;
    logic            packetValid = 1'b0;
    logic            ready;
    logic [0:0]      AWID, ARID, AWUSER, ARUSER;
    logic [6:0]      AWADDR, ARADDR;
    logic [7:0]      AWLEN, ARLEN;
    logic [2:0]      AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]      AWBURST, ARBURST;
    logic            AWLOCK, ARLOCK;
    logic [3:0]      AWCACHE, ARCACHE, AWQOS, ARQOS, AWREGION, ARREGION;
    logic            AWVALID, ARVALID, WVALID, WLAST, BREADY, bresp_err;
    logic [c_DW-1:0] WDATA;
    logic [15:0]     WSTRB;
    logic            AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
    logic [1:0]      BRESP = 2'b00;
    logic            BVALID = 1'b0, RVALID = 1'b0, RREADY = 1'b0, RLAST = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [c_DW-1:0] exp_d [6];
    logic [15:0]     exp_s [6];

    always #5 clk = ~clk;

    depacketizer dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .packetIn(packetIn), .packetValid(packetValid), .ready(ready),
        .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
        .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT),
        .M_AXI_AWQOS(AWQOS), .M_AXI_AWREGION(AWREGION), .M_AXI_AWUSER(AWUSER),
        .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
        .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
        .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK), .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT),
        .M_AXI_ARQOS(ARQOS), .M_AXI_ARREGION(ARREGION), .M_AXI_ARUSER(ARUSER),
        .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY), .M_AXI_RLAST(RLAST),
        .bresp_err(bresp_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fixed side-band fields: size=4 burst=1 lock=1 cache=3 prot=2 qos=5 region=6 user=1
    function automatic logic [c_PW-1:0] make_pkt(input logic rw, input logic [6:0] addr,
                                                  input logic [7:0] len, input logic id);
        logic [38:0] meta;
        meta = {rw, addr, id, len, 3'd4, 2'd1, 1'b1, 4'h3, 3'h2, 4'h5, 4'h6, 1'b1};
        return {63'd0, meta, exp_s[0], exp_s[1], exp_s[2], exp_s[3],
                exp_d[0], exp_d[1], exp_d[2], exp_d[3]};
    endfunction

    task automatic send(input logic [c_PW-1:0] pkt);
        packetIn    = pkt;
        packetValid = 1'b1;
        tick();
        packetValid = 1'b0;
    endtask

    task automatic set_beats(input logic [7:0] tag, input logic [15:0] s0, input logic [15:0] s1,
                             input logic [15:0] s2, input logic [15:0] s3);
        for (int i = 0; i < 4; i++) exp_d[i] = {16{tag + 8'(i)}};
        exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
        exp_d[4] = '0; exp_d[5] = '0; exp_s[4] = '0; exp_s[5] = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_beats(8'h00, 16'h0, 16'h0, 16'h0, 16'h0);
        tick(); tick();
        chk("rst_ready", ready, 1'b0);
        chk("rst_arvalid", ARVALID, 1'b0);
        chk("rst_awvalid", AWVALID, 1'b0);
        chk("rst_wvalid", WVALID, 1'b0);
        chk("rst_wlast", WLAST, 1'b0);
        chk("rst_bready", BREADY, 1'b0);
        chk("rst_bresp_err", bresp_err, 1'b0);
        chk("rst_araddr", ARADDR, 7'h00);
        rst_n = 1'b1;
        chk("ready_before_edge", ready, 1'b0);
        tick();
        chk("ready_after_rst", ready, 1'b1);

        // Read packet, ARREADY tied high
        ARREADY = 1'b1;
        send(make_pkt(1'b0, 7'h40, 8'd3, 1'b1));
        chk("rd_ready_low", ready, 1'b0);
        chk("rd_arvalid", ARVALID, 1'b1);
        chk("rd_araddr", ARADDR, 7'h40);
        chk("rd_arlen", ARLEN, 8'd3);
        chk("rd_arid", ARID, 1'b1);
        chk("rd_arsize", ARSIZE, 3'd4);
        chk("rd_arburst", ARBURST, 2'd1);
        chk("rd_arlock", ARLOCK, 1'b1);
        chk("rd_arcache", ARCACHE, 4'h3);
        chk("rd_arprot", ARPROT, 3'h2);
        chk("rd_arqos", ARQOS, 4'h5);
        chk("rd_arregion", ARREGION, 4'h6);
        chk("rd_aruser", ARUSER, 1'b1);
        chk("rd_no_awvalid", AWVALID, 1'b0);
        chk("rd_no_wvalid", WVALID, 1'b0);
        tick();
        chk("rd_arvalid_drop", ARVALID, 1'b0);
        chk("rd_ready_back", ready, 1'b1);

        // Write len=3, AWREADY delayed 5 cycles, WREADY high
        set_beats(8'hA0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        AWREADY = 1'b0; WREADY = 1'b1;
        send(make_pkt(1'b1, 7'h10, 8'd3, 1'b0));
        chk("wr_ready_low", ready, 1'b0);
        chk("wr_awvalid", AWVALID, 1'b1);
        chk("wr_awaddr", AWADDR, 7'h10);
        chk("wr_awlen", AWLEN, 8'd3);
        chk("wr_awqos", AWQOS, 4'h5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr_wvalid_%0d", i), WVALID, 1'b1);
            chk($sformatf("wr_wdata_%0d", i), WDATA, exp_d[i]);
            chk($sformatf("wr_wstrb_%0d", i), WSTRB, exp_s[i]);
            chk($sformatf("wr_wlast_%0d", i), WLAST, (i == 3));
            tick();
        end
        chk("wr_wvalid_done", WVALID, 1'b0);
        chk("wr_aw_waiting", AWVALID, 1'b1);
        chk("wr_no_bready_yet", BREADY, 1'b0);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        chk("wr_aw_dropped", AWVALID, 1'b0);
        chk("wr_bready", BREADY, 1'b1);
        BVALID = 1'b1; BRESP = 2'b00;
        tick();
        BVALID = 1'b0;
        chk("wr_bready_drop", BREADY, 1'b0);
        chk("wr_ready_back", ready, 1'b1);
        chk("wr_bresp_ok", bresp_err, 1'b0);

        // Write with WREADY toggling, then SLVERR response
        set_beats(8'hB0, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000);
        AWREADY = 1'b1;
        send(make_pkt(1'b1, 7'h20, 8'd3, 1'b1));
        chk("tg_wdata_0", WDATA, exp_d[0]);
        for (int i = 0; i < 4; i++) begin
            WREADY = 1'b1;
            tick();
            if (i < 3) begin
                chk($sformatf("tg_wdata_%0d", i + 1), WDATA, exp_d[i+1]);
                WREADY = 1'b0;
                tick();
                chk($sformatf("tg_hold_wvalid_%0d", i + 1), WVALID, 1'b1);
                chk($sformatf("tg_hold_wdata_%0d", i + 1), WDATA, exp_d[i+1]);
                chk($sformatf("tg_hold_wstrb_%0d", i + 1), WSTRB, exp_s[i+1]);
                chk($sformatf("tg_hold_wlast_%0d", i + 1), WLAST, (i == 2));
            end
        end
        chk("tg_awvalid", AWVALID, 1'b0);
        chk("tg_wvalid_done", WVALID, 1'b0);
        chk("tg_bready", BREADY, 1'b1);
        BVALID = 1'b1; BRESP = 2'b10;
        tick();
        BVALID = 1'b0; BRESP = 2'b00;
        chk("tg_bresp_err", bresp_err, 1'b1);
        chk("tg_ready_back", ready, 1'b1);
        tick();
        chk("tg_bresp_sticky", bresp_err, 1'b1);

        // Read limit; one read still outstanding from the first test
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
        tick(); tick();
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
        chk("lim_no_underflow", ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(make_pkt(1'b0, 7'h50 + 7'(i), 8'd0, 1'b0));
            chk($sformatf("lim_arvalid_%0d", i), ARVALID, 1'b1);
            tick();
            chk($sformatf("lim_ready_%0d", i), ready, (i < 3));
        end
        tick(); tick();
        chk("lim_ready_held", ready, 1'b0);
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
        tick();
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
        chk("lim_ready_after_r", ready, 1'b1);
        send(make_pkt(1'b0, 7'h60, 8'd0, 1'b0));
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
        tick();
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
        chk("lim_same_cycle", ready, 1'b1);
        send(make_pkt(1'b0, 7'h61, 8'd0, 1'b0));
        tick();
        chk("lim_full_again", ready, 1'b0);
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
        tick();
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
        chk("lim_ready_final", ready, 1'b1);

        // Write len=5: beats past the stored four are zero
        set_beats(8'hC0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        AWREADY = 1'b1; WREADY = 1'b1;
        send(make_pkt(1'b1, 7'h30, 8'd5, 1'b0));
        chk("l5_awlen", AWLEN, 8'd5);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("l5_wvalid_%0d", i), WVALID, 1'b1);
            chk($sformatf("l5_wdata_%0d", i), WDATA, exp_d[i]);
            chk($sformatf("l5_wstrb_%0d", i), WSTRB, exp_s[i]);
            chk($sformatf("l5_wlast_%0d", i), WLAST, (i == 5));
            tick();
        end
        chk("l5_bready", BREADY, 1'b1);
        chk("l5_wvalid_done", WVALID, 1'b0);
        BVALID = 1'b1;
        tick();
        BVALID = 1'b0;
        chk("l5_ready_back", ready, 1'b1);
        chk("l5_bresp_sticky", bresp_err, 1'b1);

        // Reset asserted during beat 2 of a write
        set_beats(8'hD0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        send(make_pkt(1'b1, 7'h44, 8'd3, 1'b1));
        tick(); tick();
        chk("rs_beat2_wdata", WDATA, exp_d[2]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_wvalid", WVALID, 1'b0);
        chk("rs_awvalid", AWVALID, 1'b0);
        chk("rs_wlast", WLAST, 1'b0);
        chk("rs_wdata", WDATA, '0);
        chk("rs_wstrb", WSTRB, 16'h0);
        chk("rs_awaddr", AWADDR, 7'h00);
        chk("rs_awlen", AWLEN, 8'd0);
        chk("rs_ready", ready, 1'b0);
        chk("rs_bready", BREADY, 1'b0);
        chk("rs_bresp_err", bresp_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rs_ready_after", ready, 1'b1);
        send(make_pkt(1'b0, 7'h22, 8'd0, 1'b0));
        chk("rs_rd_arvalid", ARVALID, 1'b1);
        chk("rs_rd_araddr", ARADDR, 7'h22);
        chk("rs_rd_arlen", ARLEN, 8'd0);
        tick();
        chk("rs_rd_arvalid_drop", ARVALID, 1'b0);
        chk("rs_rd_ready", ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
